seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit seven-segment display.
- Generates the 2-bit select for the 4:1 digit mux and the active-low anode enables.
- Holds shadow copies of the four digits and updates them atomically, only at frame boundaries, through a load/ack handshake from the calculator core.
- Inserts a blanking gap between digits to prevent ghosting.

Parameters:
- DIV_W, 16, width of the internal cycle counter.
- DIV_MAX, 49999, SHOW phase length minus 1, in clk cycles (must be ≥1 and fit DIV_W).
- BLANK_CYC, 64, BLANK phase length in clk cycles (must be ≥1 and fit DIV_W).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = scan display; 0 = idle with all anodes off.
- digit1, digit2, digit3, digit4  in  4 each  pending digit values; digit1 is least significant, digit4 most significant.
- load  in  1  level request to copy digit1..4 into the shadows.
- load_ack  out  1  one-cycle pulse; shadows were updated on this edge.
- shd1, shd2, shd3, shd4  out  4 each  shadow digits; these drive the mux data inputs.
- sel  out  2  mux select: 0 = shd1 … 3 = shd4.
- an  out  4  anode enables, active-low; an[i] corresponds to sel==i.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset values (asserted asynchronously): state=IDLE, cnt=0, sel=0, an=4'b1111, shd1..4=0, load_ack=0, frame_tick=0.
- All outputs are registered.
- States:
  - IDLE: an=1111, sel=0, cnt=0.
    - If enable=1, go to BLANK.
    - If load=1 in IDLE: latch digits into shadows on that edge and pulse load_ack.
  - BLANK: an=1111; runs BLANK_CYC cycles, then go to SHOW with cnt=0.
  - SHOW: an[sel]=0, all other bits 1; runs DIV_MAX+1 cycles.
    - At the end, if sel<3: sel increments, go to BLANK.
    - At the end, if sel==3: frame boundary. sel wraps to 0, go to BLANK, frame_tick pulses.
- Frame period = 4*(BLANK_CYC+DIV_MAX+1) cycles.
- Load handshake:
  - load must stay high, with digit1..4 stable, until load_ack is seen.
  - When scanning, the load is honoured only at a frame boundary edge, and only if load=1 is sampled on that edge.
  - load_ack is high for exactly one cycle. Shadows never change at any other time.
  - If load is dropped before the boundary, the request is cancelled with no ack.
  - If load is still high the cycle after the ack, it is treated as a new request (the next frame boundary, or immediately in IDLE). The requester must drop load on seeing the ack.
- enable deasserted in any state: next edge goes to IDLE (an=1111, sel=0, cnt=0).
  - A pending load in that same edge is served as an IDLE load on the following edge.
- enable re-asserted: the scan restarts at BLANK with sel=0.
- Reset mid-SHOW: an goes to 1111 immediately (asynchronously); shadows are cleared.
- Counter: cnt counts up from 0 and is cleared on every phase change. No other wrap-around exists.

Optional Feature:
- Macro: SEG_LZ_BLANK_EN.
- When defined, leading-zero suppression is applied during SHOW:
  - shd_k (k=4,3,2) is suppressed when it and every more-significant shadow digit are 0.
  - shd1 is never suppressed.
  - A suppressed digit keeps an=1111 for its SHOW slot.
  - sel sequencing and timing are unchanged.
- When undefined, all four digits are always shown.

Test Plan (DIV_MAX=3, BLANK_CYC=2):
1. Reset, then release with enable=0 → an=1111, sel=0, load_ack=0, frame_tick=0, held indefinitely. Assert rst_n=0 mid-SHOW → an=1111 within the same cycle.
2. enable=1 → repeating sequence:
   - 2 cycles an=1111, then 4 cycles an=1110 with sel=0;
   - 2 cycles blank, then 4 cycles an=1101 with sel=1;
   - same for 1011 (sel=2) and 0111 (sel=3);
   - frame_tick once every 24 cycles.
3. In IDLE, load=1 with digit1..4=1,2,3,4 → load_ack on the next edge; shd1..4=1,2,3,4.
4. Scanning, raise load at sel=1 with digits 9,8,7,6 → shadows unchanged until the end of the sel=3 SHOW. Then load_ack and frame_tick pulse on the same edge, and shd1..4=9,8,7,6.
5. Drop enable on the 2nd SHOW cycle of sel=2 → next edge an=1111, sel=0. Re-enable → BLANK for 2 cycles, then an=1110.
6. With SEG_LZ_BLANK_EN defined and shd4..1=0,0,5,0 → the sel=3 and sel=2 slots show an=1111; the sel=1 slot shows 1101; the sel=0 slot shows 1110.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Bundle between the calculator core and the seven-segment scan controller:
// pending digits with their load/ack handshake, and the registered scan outputs.
interface seg_scan_ctrl_if;
  logic       enable;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] digit4;
  logic       load;
  logic       load_ack;
  logic [3:0] shd1;
  logic [3:0] shd2;
  logic [3:0] shd3;
  logic [3:0] shd4;
  logic [1:0] sel;
  logic [3:0] an;
  logic       frame_tick;

  // Calculator core / display driver side.
  modport master (
    output enable, digit1, digit2, digit3, digit4, load,
    input  load_ack, shd1, shd2, shd3, shd4, sel, an, frame_tick
  );

  // Scan controller side.
  modport slave (
    input  enable, digit1, digit2, digit3, digit4, load,
    output load_ack, shd1, shd2, shd3, shd4, sel, an, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scan controller with blanking gaps and
// frame-atomic shadow loading. Optional leading-zero suppression: SEG_LZ_BLANK_EN.
module seg_scan_ctrl #(
  parameter int DIV_W     = 16,
  parameter int DIV_MAX   = 49999,
  parameter int BLANK_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_scan_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK_CYC - 1);
  localparam logic [DIV_W-1:0] SHOW_LAST  = DIV_W'(DIV_MAX);

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [1:0]       sel;
  logic [3:0]       an;
  logic [3:0]       shd1, shd2, shd3, shd4;
  logic             load_ack;
  logic             frame_tick;

  logic             frame_end;
  logic             take_load;
  logic [3:0]       show_an;

  always_comb begin
    frame_end = (state == SHOW) && (cnt == SHOW_LAST) && (sel == 2'd3);
    // Scanning loads land only on the frame boundary so all four digits change together.
    take_load = bus.load && ((state == IDLE) || (bus.enable && frame_end));
    show_an   = ~(4'b0001 << sel);
`ifdef SEG_LZ_BLANK_EN
    if (((sel == 2'd3) && (shd4 == 4'd0)) ||
        ((sel == 2'd2) && ({shd4, shd3} == 8'd0)) ||
        ((sel == 2'd1) && ({shd4, shd3, shd2} == 12'd0)))
      show_an = 4'b1111;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // the pre-edge values of the others; the async reset also clears the shadows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sel        <= 2'd0;
      an         <= 4'b1111;
      shd1       <= 4'd0;
      shd2       <= 4'd0;
      shd3       <= 4'd0;
      shd4       <= 4'd0;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;

      if (!bus.enable) begin
        state <= IDLE;
        cnt   <= '0;
        sel   <= 2'd0;
        an    <= 4'b1111;
      end else begin
        unique case (state)
          IDLE: begin
            state <= BLANK;
            cnt   <= '0;
            sel   <= 2'd0;
            an    <= 4'b1111;
          end
          BLANK: begin
            if (cnt == BLANK_LAST) begin
              state <= SHOW;
              cnt   <= '0;
              an    <= show_an;
            end else begin
              cnt <= cnt + DIV_W'(1);
            end
          end
          SHOW: begin
            if (cnt == SHOW_LAST) begin
              state <= BLANK;
              cnt   <= '0;
              an    <= 4'b1111;
              sel   <= sel + 2'd1;
              if (sel == 2'd3) frame_tick <= 1'b1;
            end else begin
              cnt <= cnt + DIV_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            sel   <= 2'd0;
            an    <= 4'b1111;
          end
        endcase
      end

      if (take_load) begin
        shd1     <= bus.digit1;
        shd2     <= bus.digit2;
        shd3     <= bus.digit3;
        shd4     <= bus.digit4;
        load_ack <= 1'b1;
      end
    end
  end

  assign bus.sel        = sel;
  assign bus.an         = an;
  assign bus.shd1       = shd1;
  assign bus.shd2       = shd2;
  assign bus.shd3       = shd3;
  assign bus.shd4       = shd4;
  assign bus.load_ack   = load_ack;
  assign bus.frame_tick = frame_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (DIV_MAX=3, BLANK_CYC=2): stimulus pushes the
// expected registered outputs per cycle, a negedge monitor pops and compares.
module tb_seg_scan_ctrl;

  typedef struct {
    logic [3:0]  an;
    logic [1:0]  sel;
    logic        ft;
    logic        ack;
    logic [15:0] shd;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(
    .DIV_W     (16),
    .DIV_MAX   (3),
    .BLANK_CYC (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] m_shd;
  int          pos;

  // Expected anodes during a SHOW slot; frame position p maps to slot p/6 (2 blank + 4 show).
  function automatic logic [3:0] exp_an(input int slot, input logic [15:0] s);
    logic [3:0] a;
    a = 4'b1111;
    a[slot] = 1'b0;
`ifdef SEG_LZ_BLANK_EN
    if ((slot == 3 && s[15:12] == 4'd0) || (slot == 2 && s[15:8] == 8'd0) ||
        (slot == 1 && s[15:4] == 12'd0))
      a = 4'b1111;
`endif
    return a;
  endfunction

  task automatic push(input logic [3:0] an, input logic [1:0] sel, input logic ft,
                      input logic ack, input string tag);
    exp_t e;
    e.an  = an;
    e.sel = sel;
    e.ft  = ft;
    e.ack = ack;
    e.shd = m_shd;
    e.tag = tag;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic reset_cycle(input string tag);
    m_shd = 16'h0000;
    push(4'b1111, 2'd0, 1'b0, 1'b0, tag);
  endtask

  task automatic idle_cycle(input bit in_idle, input string tag);
    logic ack;
    ack = in_idle && bus.load;
    if (ack) m_shd = {bus.digit4, bus.digit3, bus.digit2, bus.digit1};
    push(4'b1111, 2'd0, 1'b0, ack, tag);
    if (ack) bus.load = 1'b0;
  endtask

  task automatic scan_cycle(input string tag);
    int   slot;
    int   w;
    logic ft;
    logic ack;
    slot = (pos / 6) % 4;
    w    = pos % 6;
    ft   = (pos % 24 == 0) && (pos > 0);
    ack  = ft && bus.load;
    if (ack) m_shd = {bus.digit4, bus.digit3, bus.digit2, bus.digit1};
    push((w < 2) ? 4'b1111 : exp_an(slot, m_shd), 2'(slot), ft, ack, tag);
    pos++;
    if (ack) bus.load = 1'b0;
  endtask

  function automatic int cur_slot();
    return ((pos - 1) / 6) % 4;
  endfunction

  task automatic set_digits(input logic [3:0] d1, input logic [3:0] d2,
                            input logic [3:0] d3, input logic [3:0] d4);
    bus.digit1 = d1;
    bus.digit2 = d2;
    bus.digit3 = d3;
    bus.digit4 = d4;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [15:0] got_shd;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e       = q.pop_front();
        got_shd = {bus.shd4, bus.shd3, bus.shd2, bus.shd1};
        n_vec++;
        if (bus.an !== e.an || bus.sel !== e.sel || bus.frame_tick !== e.ft ||
            bus.load_ack !== e.ack || got_shd !== e.shd) begin
          n_bad++;
          $display("FAIL %s @%0t: got an=%b sel=%0d tick=%b ack=%b shd=%h, want an=%b sel=%0d tick=%b ack=%b shd=%h",
                   e.tag, $time, bus.an, bus.sel, bus.frame_tick, bus.load_ack, got_shd,
                   e.an, e.sel, e.ft, e.ack, e.shd);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n      = 1'b0;
    bus.enable = 1'b0;
    bus.load   = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    m_shd      = 16'h0000;
    pos        = 0;

    // Reset values, then idle with enable low.
    reset_cycle("reset");
    reset_cycle("reset");
    rst_n = 1'b1;
    repeat (4) idle_cycle(1'b1, "idle_hold");

    // Load while idle: ack on the next edge.
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    bus.load = 1'b1;
    idle_cycle(1'b1, "idle_load");
    idle_cycle(1'b1, "idle_after_ack");

    // Two full frames plus a little.
    bus.enable = 1'b1;
    pos = 0;
    repeat (50) scan_cycle("scan");

    // Load requested during sel=1 is deferred to the frame boundary.
    while (cur_slot() != 1) scan_cycle("scan_to_sel1");
    set_digits(4'd9, 4'd8, 4'd7, 4'd6);
    bus.load = 1'b1;
    for (int i = 0; i < 40 && bus.load; i++) scan_cycle("deferred_load");
    repeat (3) scan_cycle("after_load");

    // Request dropped before the boundary is cancelled: no ack, shadows untouched.
    while (cur_slot() != 2) scan_cycle("scan_to_sel2");
    set_digits(4'd1, 4'd1, 4'd1, 4'd1);
    bus.load = 1'b1;
    repeat (6) scan_cycle("cancel_pending");
    bus.load = 1'b0;
    repeat (12) scan_cycle("cancelled");

    // Disable on the second SHOW cycle of sel=2, with a load pending on that edge.
    while (!(cur_slot() == 2 && (pos - 1) % 6 == 3)) scan_cycle("scan_to_sel2_show2");
    bus.enable = 1'b0;
    set_digits(4'd2, 4'd4, 4'd6, 4'd8);
    bus.load = 1'b1;
    idle_cycle(1'b0, "disable");
    idle_cycle(1'b1, "late_idle_load");
    idle_cycle(1'b1, "idle_after_disable");

    // Re-enable restarts with a BLANK then sel=0.
    bus.enable = 1'b1;
    pos = 0;
    repeat (8) scan_cycle("reenable");

    // Asynchronous reset in the middle of a SHOW slot.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    m_shd = 16'h0000;
    push(4'b1111, 2'd0, 1'b0, 1'b0, "async_reset");
    bus.enable = 1'b0;
    reset_cycle("reset_hold");
    rst_n = 1'b1;
    idle_cycle(1'b1, "idle_after_reset");

    // Leading-zero pattern shd4..1 = 0,0,5,0.
    set_digits(4'd0, 4'd5, 4'd0, 4'd0);
    bus.load = 1'b1;
    idle_cycle(1'b1, "lz_load");
    bus.enable = 1'b1;
    pos = 0;
    repeat (25) scan_cycle("lz_scan");

    #1;
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
